branch_predictor: RTL

//  Dynamic branch direction predictor for the out-of-order core.
//  - Fetch side: a 2-bit saturating-counter table (BHT) indexed by PC gives a taken/not-taken prediction.
//  - Resolve side: the actual_outcome from branch resolution, with the original prediction, trains the table.
//  - Flags mispredicts and keeps branch and mispredict statistics.

---
 rtl/branch_predictor_if.sv | 26 ++
 rtl/branch_predictor.sv | 82 ++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the core and the branch direction predictor.
// The master drives requests and resolutions; the slave returns predictions and statistics.
interface branch_predictor_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 pred_valid;
    logic [31:0]          pred_pc;
    logic                 pred_taken;
    logic                 upd_valid;
    logic [31:0]          upd_pc;
    logic                 upd_predicted;
    logic                 upd_actual;
    logic                 mispredict;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispred_count;

    modport master (
        output pred_valid, pred_pc, upd_valid, upd_pc, upd_predicted, upd_actual,
        input  pred_taken, mispredict, branch_count, mispred_count
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_pc, upd_predicted, upd_actual,
        output pred_taken, mispredict, branch_count, mispred_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: a PC-indexed table of 2-bit saturating counters,
// trained by resolved outcomes, with mispredict flag and saturating branch statistics.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int CNT_WIDTH  = 32
) (
    input  logic clk,
    input  logic rst,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic [1:0]            bht_q [ENTRIES];
    logic [1:0]            bht_d [ENTRIES];
    logic                  mispredict_q, mispredict_d;
    logic [CNT_WIDTH-1:0]  branchCount_q, branchCount_d;
    logic [CNT_WIDTH-1:0]  mispredCount_q, mispredCount_d;

    logic [INDEX_BITS-1:0] predIdx;
    logic [INDEX_BITS-1:0] updIdx;
    logic [1:0]            updEntry;
    logic                  wrongPrediction;

    assign predIdx         = bp.pred_pc[INDEX_BITS+1:2];
    assign updIdx          = bp.upd_pc[INDEX_BITS+1:2];
    assign updEntry        = bht_q[updIdx];
    assign wrongPrediction = bp.upd_predicted ^ bp.upd_actual;

    // Only the index bits of each PC matter; aliasing PCs intentionally share an entry.
    logic unusedPcBits;
    assign unusedPcBits = ^{bp.pred_pc[31:INDEX_BITS+2], bp.pred_pc[1:0],
                            bp.upd_pc[31:INDEX_BITS+2], bp.upd_pc[1:0]};

    // Reads come straight from the registered table, so a same-cycle update stays invisible until next cycle.
    assign bp.pred_taken    = bp.pred_valid & bht_q[predIdx][1];
    assign bp.mispredict    = mispredict_q;
    assign bp.branch_count  = branchCount_q;
    assign bp.mispred_count = mispredCount_q;

    always_comb begin
        bht_d          = bht_q;
        mispredict_d   = bp.upd_valid & wrongPrediction;
        branchCount_d  = branchCount_q;
        mispredCount_d = mispredCount_q;

        if (bp.upd_valid) begin
            if (bp.upd_actual) begin
                if (updEntry != 2'b11) begin
                    bht_d[updIdx] = updEntry + 2'b01;
                end
            end else begin
                if (updEntry != 2'b00) begin
                    bht_d[updIdx] = updEntry - 2'b01;
                end
            end

            if (branchCount_q != '1) begin
                branchCount_d = branchCount_q + CNT_WIDTH'(1);
            end
            if (wrongPrediction && (mispredCount_q != '1)) begin
                mispredCount_d = mispredCount_q + CNT_WIDTH'(1);
            end
        end
    end

    // Reset wins over any update presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
            mispredict_q   <= 1'b0;
            branchCount_q  <= '0;
            mispredCount_q <= '0;
        end else begin
            bht_q          <= bht_d;
            mispredict_q   <= mispredict_d;
            branchCount_q  <= branchCount_d;
            mispredCount_q <= mispredCount_d;
        end
    end
endmodule
